// File: rtl/ni_target_request_tracker_pkg.sv
// Shared NoC parameters for the target-side request tracker.
//   SOURCE_WD_DEF / LEN_WD_DEF : default ID and burst-length widths
//   rsp_state_e                : response-serving FSM encoding
//   RST_ACTIVE                 : active level of the synchronous reset
package ni_target_request_tracker_pkg;

  localparam int unsigned SOURCE_WD_DEF = 8;
  localparam int unsigned LEN_WD_DEF    = 8;

  localparam logic RST_ACTIVE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } rsp_state_e;

endpackage

// File: rtl/ni_target_request_fifo.sv
// Synchronous DEPTH-entry FIFO holding tracked request records.
//   clk, rst  : clock, synchronous active-high reset (pointers/count only)
//   push      : write push_data (ignored when full unless popping too)
//   push_data : record to store
//   pop       : retire head entry (ignored when empty)
//   head_data : record at the head (valid while !empty)
//   count     : stored entries; full / empty flags derived from it
module ni_target_request_fifo
  import ni_target_request_tracker_pkg::*;
#(
  parameter int unsigned DATA_WD = 17,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_WD  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [DATA_WD-1:0] push_data,
  input  logic               pop,
  output logic [DATA_WD-1:0] head_data,
  output logic [CNT_WD-1:0]  count,
  output logic               full,
  output logic               empty
);

  localparam int unsigned PTR_WD = $clog2(DEPTH);

  logic [DATA_WD-1:0] mem [DEPTH];
  logic [PTR_WD-1:0]  wr_ptr;
  logic [PTR_WD-1:0]  rd_ptr;
  logic               do_wr;
  logic               do_rd;

  assign full      = (count == CNT_WD'(DEPTH));
  assign empty     = (count == '0);
  assign do_rd     = pop & ~empty;
  // A full FIFO still takes a write when the head is retired the same cycle.
  assign do_wr     = push & (~full | do_rd);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ni_target_request_tracker.sv
// Target-side NI request tracker: records requests needing a response and
// serves them in order to the response packetizer with beat framing.
//   clk, rst             : clock, synchronous active-high reset
//   req_*                : decoded request header from the depacketizer
//   track_full           : no free entry (registered)
//   rsp_beat_valid/accept: response beat handshake, transfer = valid & accept
//   rsp_pending/dest/is_read/first/last : current response framing
//   rsp_unexpected       : pulse, beat presented with nothing pending
//   req_overflow         : pulse, header dropped because tracker full
//   outstanding          : stored entry count
module ni_target_request_tracker
  import ni_target_request_tracker_pkg::*;
#(
  parameter int unsigned SOURCE_WD = SOURCE_WD_DEF,
  parameter int unsigned LEN_WD    = LEN_WD_DEF,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_WD    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_header_valid,
  input  logic [SOURCE_WD-1:0] req_source,
  input  logic                 req_is_read,
  input  logic [LEN_WD-1:0]    req_burst_len,
  input  logic                 req_needs_response,
  output logic                 track_full,
  input  logic                 rsp_beat_valid,
  input  logic                 rsp_beat_accept,
  output logic                 rsp_pending,
  output logic [SOURCE_WD-1:0] rsp_dest,
  output logic                 rsp_is_read,
  output logic                 rsp_first,
  output logic                 rsp_last,
  output logic                 rsp_unexpected,
  output logic                 req_overflow,
  output logic [CNT_WD-1:0]    outstanding
);

  localparam int unsigned ENTRY_WD = SOURCE_WD + 1 + LEN_WD;

  rsp_state_e           state, state_next;
  logic [LEN_WD-1:0]    beat_cnt, beat_cnt_next;

  logic                 push;
  logic                 pop;
  logic                 xfer;
  logic                 last_beat;
  logic [ENTRY_WD-1:0]  push_data;
  logic [ENTRY_WD-1:0]  head_data;
  logic [CNT_WD-1:0]    fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [SOURCE_WD-1:0] head_src;
  logic                 head_read;
  logic [LEN_WD-1:0]    head_len;

  assign push      = req_header_valid & req_needs_response;
  // Writes always answer with a single beat, so their length is stored as 0.
  assign push_data = {req_source, req_is_read, req_is_read ? req_burst_len : '0};
  assign {head_src, head_read, head_len} = head_data;

  ni_target_request_fifo #(
    .DATA_WD (ENTRY_WD),
    .DEPTH   (DEPTH),
    .CNT_WD  (CNT_WD)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign xfer      = rsp_beat_valid & rsp_beat_accept & (state != ST_IDLE);
  assign last_beat = (state == ST_HEADER) ? (head_len == '0) : (beat_cnt == head_len);
  assign pop       = xfer & last_beat;

  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) state_next = ST_HEADER;
      end
      ST_HEADER, ST_DATA: begin
        if (xfer) begin
          if (last_beat) begin
            beat_cnt_next = '0;
            // Only entries already visible count; a same-cycle push appears later.
            state_next    = (fifo_count > CNT_WD'(1)) ? ST_HEADER : ST_IDLE;
          end else begin
            beat_cnt_next = beat_cnt + 1'b1;
            state_next    = ST_DATA;
          end
        end
      end
      default: begin
        state_next    = ST_IDLE;
        beat_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      state          <= ST_IDLE;
      beat_cnt       <= '0;
      rsp_unexpected <= 1'b0;
      req_overflow   <= 1'b0;
    end else begin
      state          <= state_next;
      beat_cnt       <= beat_cnt_next;
      rsp_unexpected <= rsp_beat_valid & (state == ST_IDLE);
      req_overflow   <= push & fifo_full & ~pop;
    end
  end

  assign rsp_pending = (state != ST_IDLE);
  assign rsp_first   = (state == ST_HEADER);
  assign rsp_last    = rsp_pending & last_beat;
  assign rsp_dest    = rsp_pending ? head_src : '0;
  assign rsp_is_read = rsp_pending & head_read;
  assign track_full  = fifo_full;
  assign outstanding = fifo_count;

endmodule

// File: tb/tb_ni_target_request_tracker.sv
module tb_ni_target_request_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_header_valid;
  logic [7:0] req_source;
  logic       req_is_read;
  logic [7:0] req_burst_len;
  logic       req_needs_response;
  logic       track_full;
  logic       rsp_beat_valid;
  logic       rsp_beat_accept;
  logic       rsp_pending;
  logic [7:0] rsp_dest;
  logic       rsp_is_read;
  logic       rsp_first;
  logic       rsp_last;
  logic       rsp_unexpected;
  logic       req_overflow;
  logic [2:0] outstanding;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ni_target_request_tracker #(
    .SOURCE_WD (8),
    .LEN_WD    (8),
    .DEPTH     (4),
    .CNT_WD    (3)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req_header_valid   (req_header_valid),
    .req_source         (req_source),
    .req_is_read        (req_is_read),
    .req_burst_len      (req_burst_len),
    .req_needs_response (req_needs_response),
    .track_full         (track_full),
    .rsp_beat_valid     (rsp_beat_valid),
    .rsp_beat_accept    (rsp_beat_accept),
    .rsp_pending        (rsp_pending),
    .rsp_dest           (rsp_dest),
    .rsp_is_read        (rsp_is_read),
    .rsp_first          (rsp_first),
    .rsp_last           (rsp_last),
    .rsp_unexpected     (rsp_unexpected),
    .req_overflow       (req_overflow),
    .outstanding        (outstanding)
  );

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hdr(input logic [7:0] src, input logic rd, input logic [7:0] len,
                     input logic needs);
    req_header_valid   = 1'b1;
    req_source         = src;
    req_is_read        = rd;
    req_burst_len      = len;
    req_needs_response = needs;
  endtask

  task automatic hdr_off();
    req_header_valid   = 1'b0;
    req_source         = '0;
    req_is_read        = 1'b0;
    req_burst_len      = '0;
    req_needs_response = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hdr_off();
    rsp_beat_valid  = 1'b0;
    rsp_beat_accept = 1'b0;
    step();
    step();
    rst = 1'b0;
    n_cmp++; if (rsp_pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending got %b want 0", rsp_pending); end
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
    n_cmp++; if (track_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", track_full); end
    n_cmp++; if ({rsp_first, rsp_last, rsp_is_read, rsp_unexpected, req_overflow} !== 5'b0)
      begin n_bad++; $display("FAIL reset_flags got %b want 00000", {rsp_first, rsp_last, rsp_is_read, rsp_unexpected, req_overflow}); end
    n_cmp++; if (rsp_dest !== 8'h00) begin n_bad++; $display("FAIL reset_dest got %h want 00", rsp_dest); end
  endtask

  task automatic test_read_burst();
    hdr(8'h12, 1'b1, 8'd3, 1'b1);
    step();
    hdr_off();
    n_cmp++; if (outstanding !== 3'd1) begin n_bad++; $display("FAIL burst_count got %0d want 1", outstanding); end
    n_cmp++; if (rsp_pending !== 1'b0) begin n_bad++; $display("FAIL burst_not_yet got %b want 0", rsp_pending); end
    step();
    for (int b = 0; b < 4; b++) begin
      n_cmp++; if (rsp_pending !== 1'b1) begin n_bad++; $display("FAIL burst_pending b%0d got %b want 1", b, rsp_pending); end
      n_cmp++; if (rsp_first !== (b == 0)) begin n_bad++; $display("FAIL burst_first b%0d got %b want %b", b, rsp_first, (b == 0)); end
      n_cmp++; if (rsp_last !== (b == 3)) begin n_bad++; $display("FAIL burst_last b%0d got %b want %b", b, rsp_last, (b == 3)); end
      n_cmp++; if (rsp_dest !== 8'h12) begin n_bad++; $display("FAIL burst_dest b%0d got %h want 12", b, rsp_dest); end
      n_cmp++; if (rsp_is_read !== 1'b1) begin n_bad++; $display("FAIL burst_is_read b%0d got %b want 1", b, rsp_is_read); end
      rsp_beat_valid  = 1'b1;
      rsp_beat_accept = 1'b1;
      step();
    end
    rsp_beat_valid  = 1'b0;
    rsp_beat_accept = 1'b0;
    n_cmp++; if (rsp_pending !== 1'b0) begin n_bad++; $display("FAIL burst_idle got %b want 0", rsp_pending); end
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL burst_drained got %0d want 0", outstanding); end
  endtask

  task automatic test_back_to_back();
    hdr(8'h05, 1'b0, 8'd7, 1'b1);
    step();
    hdr(8'h09, 1'b1, 8'd0, 1'b1);
    step();
    hdr_off();
    n_cmp++; if ({rsp_pending, rsp_first, rsp_last} !== 3'b111) begin n_bad++; $display("FAIL b2b_w_frame got %b want 111", {rsp_pending, rsp_first, rsp_last}); end
    n_cmp++; if (rsp_dest !== 8'h05) begin n_bad++; $display("FAIL b2b_w_dest got %h want 05", rsp_dest); end
    n_cmp++; if (rsp_is_read !== 1'b0) begin n_bad++; $display("FAIL b2b_w_is_read got %b want 0", rsp_is_read); end
    rsp_beat_valid  = 1'b1;
    rsp_beat_accept = 1'b1;
    step();
    n_cmp++; if ({rsp_pending, rsp_first, rsp_last} !== 3'b111) begin n_bad++; $display("FAIL b2b_r_frame got %b want 111", {rsp_pending, rsp_first, rsp_last}); end
    n_cmp++; if (rsp_dest !== 8'h09) begin n_bad++; $display("FAIL b2b_r_dest got %h want 09", rsp_dest); end
    n_cmp++; if (rsp_is_read !== 1'b1) begin n_bad++; $display("FAIL b2b_r_is_read got %b want 1", rsp_is_read); end
    step();
    rsp_beat_valid  = 1'b0;
    rsp_beat_accept = 1'b0;
    n_cmp++; if (rsp_pending !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got %b want 0", rsp_pending); end
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL b2b_drained got %0d want 0", outstanding); end
  endtask

  task automatic test_full_overflow();
    logic [7:0] exp_dest [7];
    exp_dest = '{8'h21, 8'h21, 8'h22, 8'h22, 8'h23, 8'h23, 8'h25};
    for (int i = 0; i < 4; i++) begin
      hdr(8'h20 + 8'(i), 1'b1, 8'd1, 1'b1);
      step();
    end
    hdr_off();
    n_cmp++; if (outstanding !== 3'd4) begin n_bad++; $display("FAIL full_count got %0d want 4", outstanding); end
    n_cmp++; if (track_full !== 1'b1) begin n_bad++; $display("FAIL full_flag got %b want 1", track_full); end
    n_cmp++; if (req_overflow !== 1'b0) begin n_bad++; $display("FAIL full_no_ovf got %b want 0", req_overflow); end
    hdr(8'h24, 1'b1, 8'd0, 1'b1);
    step();
    hdr_off();
    n_cmp++; if (req_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse got %b want 1", req_overflow); end
    n_cmp++; if (outstanding !== 3'd4) begin n_bad++; $display("FAIL ovf_count got %0d want 4", outstanding); end
    step();
    n_cmp++; if (req_overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_one_cycle got %b want 0", req_overflow); end
    n_cmp++; if ({rsp_pending, rsp_first, rsp_dest} !== {2'b11, 8'h20}) begin n_bad++; $display("FAIL full_head got %b/%b/%h want 1/1/20", rsp_pending, rsp_first, rsp_dest); end
    rsp_beat_valid  = 1'b1;
    rsp_beat_accept = 1'b1;
    step();
    n_cmp++; if ({rsp_first, rsp_last} !== 2'b01) begin n_bad++; $display("FAIL full_data_beat got %b want 01", {rsp_first, rsp_last}); end
    hdr(8'h25, 1'b1, 8'd0, 1'b1);
    step();
    hdr_off();
    n_cmp++; if (outstanding !== 3'd4) begin n_bad++; $display("FAIL pushpop_count got %0d want 4", outstanding); end
    n_cmp++; if (track_full !== 1'b1) begin n_bad++; $display("FAIL pushpop_full got %b want 1", track_full); end
    n_cmp++; if (req_overflow !== 1'b0) begin n_bad++; $display("FAIL pushpop_no_ovf got %b want 0", req_overflow); end
    for (int k = 0; k < 7; k++) begin
      n_cmp++; if (rsp_dest !== exp_dest[k]) begin n_bad++; $display("FAIL drain_dest k%0d got %h want %h", k, rsp_dest, exp_dest[k]); end
      step();
    end
    rsp_beat_valid  = 1'b0;
    rsp_beat_accept = 1'b0;
    n_cmp++; if ({rsp_pending, outstanding} !== 4'b0000) begin n_bad++; $display("FAIL drain_idle got %b/%0d want 0/0", rsp_pending, outstanding); end
  endtask

  task automatic test_posted_write();
    hdr(8'h3c, 1'b0, 8'd0, 1'b0);
    step();
    hdr_off();
    step();
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL posted_count got %0d want 0", outstanding); end
    n_cmp++; if (rsp_pending !== 1'b0) begin n_bad++; $display("FAIL posted_pending got %b want 0", rsp_pending); end
  endtask

  task automatic test_unexpected();
    rsp_beat_valid = 1'b1;
    step();
    rsp_beat_valid = 1'b0;
    n_cmp++; if (rsp_unexpected !== 1'b1) begin n_bad++; $display("FAIL unexp_pulse got %b want 1", rsp_unexpected); end
    n_cmp++; if (rsp_pending !== 1'b0) begin n_bad++; $display("FAIL unexp_pending got %b want 0", rsp_pending); end
    step();
    n_cmp++; if (rsp_unexpected !== 1'b0) begin n_bad++; $display("FAIL unexp_one_cycle got %b want 0", rsp_unexpected); end
  endtask

  task automatic test_reset_mid_burst();
    hdr(8'h33, 1'b1, 8'd5, 1'b1);
    step();
    hdr_off();
    step();
    rsp_beat_valid  = 1'b1;
    rsp_beat_accept = 1'b1;
    step();
    step();
    step();
    rsp_beat_valid  = 1'b0;
    rsp_beat_accept = 1'b0;
    n_cmp++; if ({rsp_pending, rsp_first, rsp_last} !== 3'b100) begin n_bad++; $display("FAIL midrst_in_data got %b want 100", {rsp_pending, rsp_first, rsp_last}); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if ({rsp_pending, rsp_first, rsp_last, rsp_is_read} !== 4'b0000) begin n_bad++; $display("FAIL midrst_flags got %b want 0000", {rsp_pending, rsp_first, rsp_last, rsp_is_read}); end
    n_cmp++; if (rsp_dest !== 8'h00) begin n_bad++; $display("FAIL midrst_dest got %h want 00", rsp_dest); end
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL midrst_count got %0d want 0", outstanding); end
    n_cmp++; if ({rsp_unexpected, req_overflow} !== 2'b00) begin n_bad++; $display("FAIL midrst_pulses got %b want 00", {rsp_unexpected, req_overflow}); end
    hdr(8'h44, 1'b1, 8'd0, 1'b1);
    step();
    hdr_off();
    step();
    n_cmp++; if ({rsp_pending, rsp_first, rsp_last} !== 3'b111) begin n_bad++; $display("FAIL postrst_frame got %b want 111", {rsp_pending, rsp_first, rsp_last}); end
    n_cmp++; if (rsp_dest !== 8'h44) begin n_bad++; $display("FAIL postrst_dest got %h want 44", rsp_dest); end
    rsp_beat_valid  = 1'b1;
    rsp_beat_accept = 1'b1;
    step();
    rsp_beat_valid  = 1'b0;
    rsp_beat_accept = 1'b0;
    n_cmp++; if ({rsp_pending, outstanding} !== 4'b0000) begin n_bad++; $display("FAIL postrst_drained got %b/%0d want 0/0", rsp_pending, outstanding); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_burst();
    test_back_to_back();
    test_full_overflow();
    test_posted_write();
    test_unexpected();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
